// File: rtl/calc2_port_responder.sv
// calc2_port_responder: DUT-side end of one calc2 request port.
// A request takes two cycles: the command, operand 1 and tag, then operand 2.
// The add, sub and shift result is returned as a one-cycle tagged response
// LATENCY edges after the edge that samples operand 2.
// Optional feature macro: CALC2_SHIFT_EN. When it is defined, commands 5 and 6
// execute as logical shifts. When it is undefined, the shifter is left out and
// commands 5 and 6 answer with an error response.
module calc2_port_responder #(
    parameter int unsigned LATENCY = 3
) (
    input  logic        c_clk,
    input  logic        reset_n,
    input  logic [3:0]  req_cmd_in,
    input  logic [31:0] req_data_in,
    input  logic [1:0]  req_tag_in,
    output logic [1:0]  out_resp,
    output logic [31:0] out_data,
    output logic [1:0]  out_tag
);

    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    typedef enum logic {
        S_IDLE,
        S_OP2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_push;

    // First-cycle capture of the request
    logic [3:0]  r_cmd;
    logic [31:0] r_op1;
    logic [1:0]  r_tag;
    logic        r_dup;

    // Execution result for the request in its operand-2 cycle
    logic [32:0] w_sum;
    logic [1:0]  w_res_resp;
    logic [31:0] w_res_data;

    // Delay line: one entry per stage
    logic [LATENCY-1:0] r_dl_valid;
    logic [LATENCY-1:0] r_dl_own;
    logic [1:0]         r_dl_resp [LATENCY];
    logic [31:0]        r_dl_data [LATENCY];
    logic [1:0]         r_dl_tag  [LATENCY];

    // Outstanding-tag table
    logic [3:0]  r_tags;
    logic [3:0]  w_clr_vec;
    logic [3:0]  w_set_vec;
    logic        w_dup;

    // FSM state register
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a nonzero command in IDLE always leads to the operand-2 cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_cmd_in != '0) w_state_nxt = S_OP2;
            S_OP2:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: accept in IDLE, push the computed result in OP2
    always_comb begin
        w_accept = 1'b0;
        w_push   = 1'b0;
        case (r_state)
            S_IDLE:  w_accept = (req_cmd_in != '0);
            S_OP2:   w_push   = 1'b1;
            default: ;
        endcase
    end

    // Tag bookkeeping. A response that is emitted on this edge clears its tag
    // before the duplicate test, so that tag can be accepted again on the same edge.
    always_comb begin
        w_clr_vec = '0;
        if (r_dl_valid[LATENCY-1] && r_dl_own[LATENCY-1]) begin
            w_clr_vec = 4'b0001 << r_dl_tag[LATENCY-1];
        end
        w_dup     = r_tags[req_tag_in] & ~w_clr_vec[req_tag_in];
        w_set_vec = '0;
        if (w_accept && !w_dup) begin
            w_set_vec = 4'b0001 << req_tag_in;
        end
    end

    // Outstanding-tag table update
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tags <= '0;
        end else begin
            r_tags <= (r_tags & ~w_clr_vec) | w_set_vec;
        end
    end

    // Capture the command, operand 1, tag and duplicate status on accept
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd <= '0;
            r_op1 <= '0;
            r_tag <= '0;
            r_dup <= 1'b0;
        end else if (w_accept) begin
            r_cmd <= req_cmd_in;
            r_op1 <= req_data_in;
            r_tag <= req_tag_in;
            r_dup <= w_dup;
        end
    end

    // Compute the response from the captured operand 1 and the live operand 2
    always_comb begin
        w_sum      = {1'b0, r_op1} + {1'b0, req_data_in};
        w_res_resp = RESP_ERR;
        w_res_data = '0;
        case (r_cmd)
            4'd1: begin
                if (!w_sum[32]) begin
                    w_res_resp = RESP_OK;
                    w_res_data = w_sum[31:0];
                end
            end
            4'd2: begin
                if (req_data_in <= r_op1) begin
                    w_res_resp = RESP_OK;
                    w_res_data = r_op1 - req_data_in;
                end
            end
`ifdef CALC2_SHIFT_EN
            4'd5: begin
                w_res_resp = RESP_OK;
                w_res_data = r_op1 << req_data_in[4:0];
            end
            4'd6: begin
                w_res_resp = RESP_OK;
                w_res_data = r_op1 >> req_data_in[4:0];
            end
`endif
            default: ;
        endcase
        if (r_dup) begin
            w_res_resp = RESP_ERR;
            w_res_data = '0;
        end
    end

    // Delay line: stage 0 takes the new result, and every stage shifts each cycle.
    // A duplicate-tag entry does not own its tag, so its emission leaves the tag bit set.
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_valid <= '0;
            r_dl_own   <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_dl_resp[i] <= '0;
                r_dl_data[i] <= '0;
                r_dl_tag[i]  <= '0;
            end
        end else begin
            r_dl_valid[0] <= w_push;
            r_dl_own[0]   <= w_push & ~r_dup;
            r_dl_resp[0]  <= w_push ? w_res_resp : 2'd0;
            r_dl_data[0]  <= w_push ? w_res_data : 32'd0;
            r_dl_tag[0]   <= w_push ? r_tag : 2'd0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
                r_dl_own[i]   <= r_dl_own[i-1];
                r_dl_resp[i]  <= r_dl_resp[i-1];
                r_dl_data[i]  <= r_dl_data[i-1];
                r_dl_tag[i]   <= r_dl_tag[i-1];
            end
        end
    end

    // Output registers load the last stage, or all zeros when it is empty
    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else if (r_dl_valid[LATENCY-1]) begin
            out_resp <= r_dl_resp[LATENCY-1];
            out_data <= r_dl_data[LATENCY-1];
            out_tag  <= r_dl_tag[LATENCY-1];
        end else begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end
    end

endmodule

// File: tb/tb_calc2_port_responder.sv
// Scoreboard bench for calc2_port_responder. Every request pushes its expected
// response and its expected emission cycle. A monitor on the falling edge
// either pops and compares the response due in that cycle or checks that the
// outputs are idle.
module tb_calc2_port_responder;

    localparam int LAT = 3;

    logic        c_clk;
    logic        reset_n;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  req_tag_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;

    calc2_port_responder #(.LATENCY(LAT)) dut (
        .c_clk       (c_clk),
        .reset_n     (reset_n),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        bit          own;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_emit = 0;

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
        end
    endtask

    // Reference behaviour of one request: returns {resp, data}
    function automatic logic [33:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input bit dup);
        logic [32:0] s;
        if (dup) return {2'd2, 32'd0};
        case (cmd)
            4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                return s[32] ? {2'd2, 32'd0} : {2'd1, s[31:0]};
            end
            4'd2: return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
`ifdef CALC2_SHIFT_EN
            4'd5: return {2'd1, a << b[4:0]};
            4'd6: return {2'd1, a >> b[4:0]};
`endif
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    // Two-cycle request. The command is sampled at edge e0, operand 2 at e0+1,
    // and the response shows after edge e0+1+LAT.
    task automatic send(input logic [3:0] cmd, input logic [31:0] op1,
                        input logic [1:0] tag, input logic [31:0] op2);
        int          e0;
        bit          dup;
        logic [33:0] r;
        exp_t        e;
        @(negedge c_clk);
        e0 = cyc + 1;
        req_cmd_in  = cmd;
        req_data_in = op1;
        req_tag_in  = tag;
        dup = 1'b0;
        foreach (q[i]) if (q[i].own && q[i].tag == tag && q[i].cyc > e0) dup = 1'b1;
        r = model(cmd, op1, op2, dup);
        e.cyc  = e0 + 1 + LAT;
        e.resp = r[33:32];
        e.data = r[31:0];
        e.tag  = tag;
        e.own  = !dup;
        q.push_back(e);
        last_emit = e.cyc;
        @(negedge c_clk);
        req_cmd_in  = 4'd0;
        req_data_in = op2;
        req_tag_in  = 2'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge c_clk);
    endtask

    // Monitor: compare the response due in this cycle, otherwise require idle outputs
    always @(negedge c_clk) begin
        exp_t e;
        if (reset_n) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check("resp", 64'(out_resp), 64'(e.resp));
                check("data", 64'(out_data), 64'(e.data));
                check("tag",  64'(out_tag),  64'(e.tag));
            end else begin
                check("idle", {28'd0, out_resp, out_data, out_tag}, 64'd0);
            end
        end
    end

    initial begin
        logic [3:0] cmds [6];
        cmds[0] = 4'd1; cmds[1] = 4'd2; cmds[2] = 4'd5;
        cmds[3] = 4'd6; cmds[4] = 4'd3; cmds[5] = 4'd15;

        reset_n     = 1'b0;
        req_cmd_in  = '0;
        req_data_in = '0;
        req_tag_in  = '0;
        idle(3);
        check("rst_resp", 64'(out_resp), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_tag",  64'(out_tag),  64'd0);
        reset_n = 1'b1;
        idle(2);

        // Basic add
        send(4'd1, 32'h30, 2'd1, 32'h20);
        idle(LAT + 2);

        // Overflow, underflow, and exact subtract
        send(4'd1, 32'hFFFF_FFFF, 2'd0, 32'h1);
        send(4'd2, 32'h5, 2'd2, 32'h6);
        send(4'd2, 32'h6, 2'd3, 32'h5);
        idle(LAT + 2);

        // Shifts (an error response unless the shifter is built in)
        send(4'd5, 32'h1, 2'd0, 32'h24);
        send(4'd6, 32'h8000_0000, 2'd1, 32'd31);
        idle(LAT + 2);

        // Back-to-back tags 0..3
        for (int i = 0; i < 4; i++) send(4'd1, 32'(i * 16), 2'(i), 32'(i + 1));
        idle(LAT + 2);

        // A repeated tag while outstanding is an error; on the clearing edge it is accepted again
        send(4'd1, 32'h100, 2'd1, 32'h1);
        send(4'd1, 32'h200, 2'd1, 32'h2);
        send(4'd1, 32'h300, 2'd1, 32'h3);
        idle(LAT + 2);

        // Invalid commands still take two cycles
        send(4'd15, 32'h1234, 2'd3, 32'h1);
        send(4'd1, 32'h7, 2'd0, 32'h8);
        send(4'd3, 32'h1, 2'd1, 32'h1);
        send(4'd4, 32'h1, 2'd2, 32'h1);
        send(4'd7, 32'h1, 2'd3, 32'h1);
        idle(LAT + 2);

        // Reset in the cycle after E1: the pending response is dropped
        send(4'd1, 32'h11, 2'd2, 32'h22);
        @(negedge c_clk);
        #1 reset_n = 1'b0;
        #1;
        check("rstA_resp", 64'(out_resp), 64'd0);
        check("rstA_data", 64'(out_data), 64'd0);
        check("rstA_tag",  64'(out_tag),  64'd0);
        q.delete();
        idle(2);
        reset_n = 1'b1;
        idle(LAT + 3);
        send(4'd1, 32'h40, 2'd2, 32'h2);
        idle(LAT + 2);

        // Reset while a response is visible clears the outputs at once
        send(4'd2, 32'h99, 2'd1, 32'h9);
        while (cyc < last_emit) @(negedge c_clk);
        #2;
        check("pre_rst_resp", 64'(out_resp), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rstB_resp", 64'(out_resp), 64'd0);
        check("rstB_data", 64'(out_data), 64'd0);
        check("rstB_tag",  64'(out_tag),  64'd0);
        q.delete();
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // Random mix with tag reuse
        for (int i = 0; i < 30; i++) begin
            send(cmds[$urandom_range(0, 5)],
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)));
            idle($urandom_range(0, 2));
        end

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge c_clk);
        if (q.size() > 0) check("drain", 64'(q.size()), 64'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
